cdb_arbiter: RTL and testbench

Arbitrates between the functional units of the out-of-order core for the single result broadcast bus (CDB) feeding the writeback/result pipeline register. Each functional unit owns a one-entry holding slot, so a unit can drop its result and continue without waiting for a grant. A round-robin arbiter selects one full slot per cycle and drives a registered broadcast of we/dst/tag/data. A synchronous flush discards all pending results on mispredict or exception.

---
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 tb/tb_cdb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Result broadcast arbiter: one holding slot per functional unit, round-robin
// selection onto a registered common data bus, with synchronous flush.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DST_W  = 5,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [N_REQ-1:0]         fu_valid,
    output logic [N_REQ-1:0]         fu_ready,
    input  logic [N_REQ-1:0]         fu_we,
    input  logic [N_REQ*DST_W-1:0]   fu_dst,
    input  logic [N_REQ*TAG_W-1:0]   fu_tag,
    input  logic [N_REQ*DATA_W-1:0]  fu_data,
    output logic                     cdb_valid,
    output logic                     cdb_we,
    output logic [DST_W-1:0]         cdb_dst,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [$clog2(N_REQ)-1:0] cdb_src
);
    localparam int SRC_W = $clog2(N_REQ);

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] p);
        return (p == SRC_W'(N_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [N_REQ-1:0]  full_q, full_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  we_q;
    logic [DST_W-1:0]  dst_q  [N_REQ];
    logic [TAG_W-1:0]  tag_q  [N_REQ];
    logic [DATA_W-1:0] data_q [N_REQ];

    logic              cdb_valid_q, cdb_we_q;
    logic [DST_W-1:0]  cdb_dst_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [SRC_W-1:0]  cdb_src_q;

    logic              blocked;
    logic              grant_vld;
    logic [SRC_W-1:0]  winner, cand;
    logic [N_REQ-1:0]  grant, accept;

    assign blocked = rst | flush;

    // Winner is the first full slot at or after ptr; independent of fu_valid.
    always_comb begin
        grant_vld = 1'b0;
        winner    = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_vld && full_q[cand]) begin
                grant_vld = 1'b1;
                winner    = cand;
            end
            cand = wrap_inc(cand);
        end
        if (blocked) begin
            grant_vld = 1'b0;
        end
    end

    assign grant    = grant_vld ? ({{(N_REQ-1){1'b0}}, 1'b1} << winner) : '0;
    assign fu_ready = {N_REQ{~blocked}} & (~full_q | grant);
    assign accept   = fu_valid & fu_ready;
    assign full_d   = (full_q & ~grant) | accept;
    assign ptr_d    = grant_vld ? wrap_inc(winner) : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_we_q    <= 1'b0;
            cdb_dst_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else if (flush) begin
            full_q      <= '0;
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_we_q    <= 1'b0;
        end else begin
            full_q      <= full_d;
            ptr_q       <= ptr_d;
            cdb_valid_q <= grant_vld;
            cdb_we_q    <= grant_vld & we_q[winner];
            if (grant_vld) begin
                cdb_dst_q  <= dst_q[winner];
                cdb_tag_q  <= tag_q[winner];
                cdb_data_q <= data_q[winner];
                cdb_src_q  <= winner;
            end
        end
    end

    // Slot payload is only meaningful while its full bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                we_q[i]   <= fu_we[i];
                dst_q[i]  <= fu_dst[i*DST_W +: DST_W];
                tag_q[i]  <= fu_tag[i*TAG_W +: TAG_W];
                data_q[i] <= fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_we    = cdb_we_q;
    assign cdb_dst   = cdb_dst_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued in grant
// order when stimulus is issued and compared as the bus delivers them.
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  fu_valid;
    logic [3:0]  fu_ready;
    logic [3:0]  fu_we;
    logic [19:0] fu_dst;
    logic [19:0] fu_tag;
    logic [127:0] fu_data;
    logic        cdb_valid, cdb_we;
    logic [4:0]  cdb_dst, cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;

    typedef struct packed {
        logic        we;
        logic [4:0]  dst;
        logic [4:0]  tag;
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] rdy_hist [8];
    int   sc;

    cdb_arbiter #(.N_REQ(4), .DST_W(5), .TAG_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_we(fu_we),
        .fu_dst(fu_dst), .fu_tag(fu_tag), .fu_data(fu_data),
        .cdb_valid(cdb_valid), .cdb_we(cdb_we), .cdb_dst(cdb_dst),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic        gen_we(input int i, input int j);   return ((i + j) % 3) != 2; endfunction
    function automatic logic [4:0]  gen_dst(input int i, input int j);  return 5'(i * 4 + j); endfunction
    function automatic logic [4:0]  gen_tag(input int i, input int j);  return 5'(i + 4 * j + 1); endfunction
    function automatic logic [31:0] gen_data(input int i, input int j); return 32'hA500_0000 | 32'(i << 8) | 32'(j); endfunction

    function automatic exp_t mk(input int i, input int j);
        exp_t x;
        x.we = gen_we(i, j); x.dst = gen_dst(i, j); x.tag = gen_tag(i, j);
        x.data = gen_data(i, j); x.src = 2'(i);
        return x;
    endfunction

    task automatic drive_raw(input int i, input logic v, input logic we, input logic [4:0] dst,
                             input logic [4:0] tag, input logic [31:0] data);
        fu_valid[i]         = v;
        fu_we[i]            = we;
        fu_dst[i*5 +: 5]    = dst;
        fu_tag[i*5 +: 5]    = tag;
        fu_data[i*32 +: 32] = data;
    endtask

    task automatic drive_fu(input int i, input logic v, input int j);
        drive_raw(i, v, gen_we(i, j), gen_dst(i, j), gen_tag(i, j), gen_data(i, j));
    endtask

    task automatic idle(input int n);
        fu_valid = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Each unit in mask offers nitems results, holding each until accepted.
    task automatic stream(input logic [3:0] mask, input int nitems, input int budget, output int send_cycles);
        int sent[4];
        logic [3:0] acc;
        int cyc;
        logic all_sent;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        for (int k = 0; k < 8; k++) rdy_hist[k] = '0;
        send_cycles = -1;
        cyc = 0;
        while (cyc < budget) begin
            for (int i = 0; i < 4; i++) drive_fu(i, mask[i] && (sent[i] < nitems), sent[i]);
            @(negedge clk);
            if (cyc < 8) rdy_hist[cyc] = fu_ready;
            acc = fu_valid & fu_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (acc[i]) sent[i]++;
            cyc++;
            all_sent = 1'b1;
            for (int i = 0; i < 4; i++) if (mask[i] && sent[i] < nitems) all_sent = 1'b0;
            if (all_sent && send_cycles < 0) send_cycles = cyc;
            if (send_cycles >= 0 && exp_q.size() == 0) break;
        end
        fu_valid = '0;
        chk("stream_drained", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && cdb_valid) begin
            if (exp_q.size() == 0) begin
                chk("cdb_unexpected_valid", 64'(cdb_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("cdb_src",  64'(cdb_src),  64'(e.src));
                chk("cdb_we",   64'(cdb_we),   64'(e.we));
                chk("cdb_dst",  64'(cdb_dst),  64'(e.dst));
                chk("cdb_tag",  64'(cdb_tag),  64'(e.tag));
                chk("cdb_data", 64'(cdb_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        fu_valid = 4'hF; fu_we = 4'hF; fu_dst = '1; fu_tag = '1; fu_data = '1;
        #1;
        chk("rst_ready_comb", 64'(fu_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(fu_ready), 64'h0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_cdb_we",    64'(cdb_we),    64'h0);
        chk("rst_cdb_dst",   64'(cdb_dst),   64'h0);
        chk("rst_cdb_tag",   64'(cdb_tag),   64'h0);
        chk("rst_cdb_data",  64'(cdb_data),  64'h0);
        chk("rst_cdb_src",   64'(cdb_src),   64'h0);
        rst = 1'b0; fu_valid = '0;
        @(negedge clk);
        chk("post_rst_ready", 64'(fu_ready), 64'hF);
        @(posedge clk); #1;

        // Single requester latency
        drive_raw(2, 1'b1, 1'b1, 5'd7, 5'd3, 32'hDEAD_BEEF);
        exp_q.push_back('{we: 1'b1, dst: 5'd7, tag: 5'd3, data: 32'hDEAD_BEEF, src: 2'd2});
        @(negedge clk);
        chk("single_ready", 64'(fu_ready[2]), 64'd1);
        chk("single_c0_valid", 64'(cdb_valid), 64'd0);
        @(posedge clk); #1; fu_valid = '0;
        @(negedge clk); chk("single_c1_valid", 64'(cdb_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("single_c2_valid", 64'(cdb_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("single_c3_valid", 64'(cdb_valid), 64'd0);
        @(posedge clk); #1;

        // we=0 result
        drive_raw(0, 1'b1, 1'b0, 5'd1, 5'd9, 32'h0000_1234);
        exp_q.push_back('{we: 1'b0, dst: 5'd1, tag: 5'd9, data: 32'h0000_1234, src: 2'd0});
        @(posedge clk); #1; fu_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("we0_valid", 64'(cdb_valid), 64'd1);
        chk("we0_we", 64'(cdb_we), 64'd0);
        @(posedge clk); #1;

        // Idle flush to bring ptr back to 0
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle(2);

        // Full contention: src 0,1,2,3 repeating, tags 1..12 in order
        for (int j = 0; j < 3; j++) for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, j));
        stream(4'hF, 3, 60, sc);
        chk("cont_ready_c0", 64'(rdy_hist[0]), 64'hF);
        chk("cont_ready_c1", 64'(rdy_hist[1]), 64'h1);
        chk("cont_ready_c2", 64'(rdy_hist[2]), 64'h2);
        idle(3);

        // Back-pressure: FU1 blocked while slot 1 waits behind slot 0
        exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0));
        exp_q.push_back(mk(0, 1)); exp_q.push_back(mk(1, 1));
        stream(4'b0011, 2, 40, sc);
        chk("bp_ready1_blocked", 64'(rdy_hist[1][1]), 64'd0);
        chk("bp_ready1_freed",   64'(rdy_hist[2][1]), 64'd1);
        idle(3);

        // FU1 alone: one accept per cycle
        for (int j = 0; j < 5; j++) exp_q.push_back(mk(1, j));
        stream(4'b0010, 5, 40, sc);
        chk("stream1_cycles", 64'(sc), 64'd5);
        for (int k = 0; k < 5; k++) chk("stream1_ready", 64'(rdy_hist[k][1]), 64'd1);
        idle(3);

        // Flush with all slots full and fu_valid still high
        for (int i = 0; i < 4; i++) drive_fu(i, 1'b1, 6);
        @(negedge clk); chk("flush_fill_ready", 64'(fu_ready), 64'hF);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(fu_ready), 64'h0);
        chk("flush_c0_valid", 64'(cdb_valid), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; fu_valid = '0;
        @(negedge clk);
        chk("flush_c1_valid", 64'(cdb_valid), 64'd0);
        chk("flush_ready_after", 64'(fu_ready), 64'hF);
        @(posedge clk); #1;
        idle(3);
        // ptr restarted at 0: fresh simultaneous requests broadcast 0,1,2,3
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 0));
        stream(4'hF, 1, 30, sc);
        idle(3);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
